// File: rtl/spike_aer_encoder_if.sv
// ----------------------------------------------------------------------------
// spike_aer_encoder_if
// Bundles the spike-frame input and the address-event output of the AER
// encoder.
//   spikes    : parallel spike vector, bit i = neuron i
//   step      : timestep strobe requesting capture of spikes
//   ev_valid  : event address presented
//   ev_ready  : downstream accepts the event
//   ev_addr   : neuron index of the current event (0 when idle)
//   ev_last   : current event is the final one of the frame (0 when idle)
//   spike_cnt : popcount of the last captured frame
//   busy      : frame in progress
//   done      : one-cycle pulse, frame fully drained
//   overflow  : one-cycle pulse, step dropped while busy
// Modports: master = encoder side, slave = neuron array / router side.
// ----------------------------------------------------------------------------
interface spike_aer_encoder_if #(
   parameter int N  = 8,
   parameter int AW = 3
);
   logic [N-1:0]  spikes;
   logic          step;
   logic          ev_valid;
   logic          ev_ready;
   logic [AW-1:0] ev_addr;
   logic          ev_last;
   logic [AW:0]   spike_cnt;
   logic          busy;
   logic          done;
   logic          overflow;

   modport master (
      input  spikes, step, ev_ready,
      output ev_valid, ev_addr, ev_last, spike_cnt, busy, done, overflow
   );

   modport slave (
      output spikes, step, ev_ready,
      input  ev_valid, ev_addr, ev_last, spike_cnt, busy, done, overflow
   );
endinterface

// File: rtl/spike_aer_encoder.sv
// ----------------------------------------------------------------------------
// spike_aer_encoder
// Captures the spike vector once per timestep and emits only the active
// neurons, lowest index first, one address per valid/ready handshake.
// Silent neurons cost no output cycles.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset; aborts any frame in progress
//   bus   : spike_aer_encoder_if.master (see interface for signal list)
// ----------------------------------------------------------------------------
module spike_aer_encoder #(
   parameter int N  = 8,
   parameter int AW = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   spike_aer_encoder_if.master  bus
);

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   state_t        r_state;
   logic [N-1:0]  r_pending;
   logic [AW:0]   r_spike_cnt;
   logic          r_done;
   logic          r_overflow;

   logic [AW-1:0] w_low;
   logic [N-1:0]  w_low_mask;
   logic          w_single;
   logic          w_scan;

   // Population count of a spike vector.
   function automatic logic [AW:0] popcount(input logic [N-1:0] v);
      logic [AW:0] c;
      c = {(AW+1){1'b0}};
      for (int i = 0; i < N; i++) begin
         c = c + {{AW{1'b0}}, v[i]};
      end
      return c;
   endfunction

   // Priority encoder: lowest set index of pending (scan high to low so the
   // lowest index wins).
   always_comb begin
      w_low = {AW{1'b0}};
      for (int i = N - 1; i >= 0; i--) begin
         w_low = r_pending[i] ? AW'(i) : w_low;
      end
   end

   assign w_scan     = (r_state == SCAN);
   assign w_low_mask = N'(1'b1) << w_low;
   // Exactly one bit left: clearing the lowest bit leaves nothing.
   assign w_single   = (r_pending != {N{1'b0}}) &&
                       ((r_pending & (r_pending - N'(1'b1))) == {N{1'b0}});

   // Frame control: capture on step in IDLE, drain one event per handshake in
   // SCAN, pulse done/overflow for a single cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_pending   <= {N{1'b0}};
         r_spike_cnt <= {(AW+1){1'b0}};
         r_done      <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         r_done     <= 1'b0;
         r_overflow <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.step) begin
                  r_pending   <= bus.spikes;
                  r_spike_cnt <= popcount(bus.spikes);
                  if (bus.spikes != {N{1'b0}}) begin
                     r_state <= SCAN;
                  end else begin
                     r_done <= 1'b1;
                  end
               end
            end
            SCAN: begin
               // A step while busy is dropped, even on the final handshake.
               if (bus.step) begin
                  r_overflow <= 1'b1;
               end
               if (bus.ev_ready) begin
                  r_pending <= r_pending & ~w_low_mask;
                  if (w_single) begin
                     r_state <= IDLE;
                     r_done  <= 1'b1;
                  end
               end
            end
            default: begin
               r_state   <= IDLE;
               r_pending <= {N{1'b0}};
            end
         endcase
      end
   end

   assign bus.ev_valid  = w_scan;
   assign bus.ev_addr   = w_scan ? w_low : {AW{1'b0}};
   assign bus.ev_last   = w_scan & w_single;
   assign bus.spike_cnt = r_spike_cnt;
   assign bus.busy      = w_scan;
   assign bus.done      = r_done;
   assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_spike_aer_encoder.sv
// ----------------------------------------------------------------------------
// tb_spike_aer_encoder
// Directed stimulus with a scoreboard: each frame pushes its expected events
// into a queue; a monitor pops and compares on every handshake.
// ----------------------------------------------------------------------------
module tb_spike_aer_encoder;

   localparam int N  = 8;
   localparam int AW = 3;

   logic clk;
   logic rst_n;

   int checks;
   int errors;
   int hs_count;

   typedef struct {
      int addr;
      int last;
   } ev_t;

   ev_t exp_q[$];

   spike_aer_encoder_if #(.N(N), .AW(AW)) bus ();

   spike_aer_encoder #(.N(N), .AW(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected events: ascending set bits, last flag on the highest one.
   task automatic push_frame(input logic [N-1:0] spk);
      int hi;
      ev_t e;
      hi = -1;
      for (int i = 0; i < N; i++) if (spk[i]) hi = i;
      for (int i = 0; i < N; i++) begin
         if (spk[i]) begin
            e.addr = i;
            e.last = (i == hi) ? 1 : 0;
            exp_q.push_back(e);
         end
      end
   endtask

   // Issue one step and follow the frame until done, checking busy length.
   task automatic run_frame(input logic [N-1:0] spk, input int exp_busy, input int exp_cnt);
      int nb;
      int got;
      push_frame(spk);
      bus.spikes = spk;
      bus.step   = 1'b1;
      tick();
      bus.step   = 1'b0;
      nb  = 0;
      got = 0;
      for (int c = 0; c < 40; c++) begin
         if (bus.done) begin
            got = 1;
            break;
         end
         nb += int'(bus.busy);
         tick();
      end
      chk("done_seen", got, 1);
      chk("busy_cycles", nb, exp_busy);
      chk("spike_cnt", int'(bus.spike_cnt), exp_cnt);
      tick();
      chk("done_one_cycle", int'(bus.done), 0);
   endtask

   // Scoreboard monitor: compare every handshake against the queue head.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.ev_valid && bus.ev_ready) begin
            hs_count++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_event: addr %0d last %0d, none expected", bus.ev_addr, bus.ev_last);
            end else begin
               ev_t e;
               e = exp_q.pop_front();
               chk("ev_addr", int'(bus.ev_addr), e.addr);
               chk("ev_last", int'(bus.ev_last), e.last);
            end
         end else if (!bus.ev_valid) begin
            chk("idle_addr_zero", int'(bus.ev_addr), 0);
            chk("idle_last_zero", int'(bus.ev_last), 0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int hs0;
      checks   = 0;
      errors   = 0;
      hs_count = 0;

      // Reset held with step and a full vector present.
      rst_n        = 1'b0;
      bus.step     = 1'b1;
      bus.spikes   = 8'hFF;
      bus.ev_ready = 1'b1;
      tick();
      tick();
      chk("rst_valid", int'(bus.ev_valid), 0);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_cnt", int'(bus.spike_cnt), 0);
      chk("rst_done", int'(bus.done), 0);
      chk("rst_ovf", int'(bus.overflow), 0);
      chk("rst_addr", int'(bus.ev_addr), 0);
      bus.step = 1'b0;
      rst_n    = 1'b1;
      tick();
      tick();
      chk("post_rst_valid", int'(bus.ev_valid), 0);

      // 0xA4: events 2, 5, 7.
      run_frame(8'hA4, 3, 3);

      // Backpressure on 0x81.
      hs0 = hs_count;
      push_frame(8'h81);
      bus.ev_ready = 1'b0;
      bus.spikes   = 8'h81;
      bus.step     = 1'b1;
      tick();
      bus.step = 1'b0;
      for (int c = 0; c < 4; c++) begin
         chk("bp_valid", int'(bus.ev_valid), 1);
         chk("bp_addr", int'(bus.ev_addr), 0);
         chk("bp_last", int'(bus.ev_last), 0);
         tick();
      end
      bus.ev_ready = 1'b1;
      tick();
      chk("bp_second_addr", int'(bus.ev_addr), 7);
      chk("bp_second_last", int'(bus.ev_last), 1);
      tick();
      chk("bp_done", int'(bus.done), 1);
      chk("bp_handshakes", hs_count - hs0, 2);
      tick();

      // Empty frame.
      bus.spikes = 8'h00;
      bus.step   = 1'b1;
      tick();
      bus.step = 1'b0;
      chk("empty_valid", int'(bus.ev_valid), 0);
      chk("empty_done", int'(bus.done), 1);
      chk("empty_cnt", int'(bus.spike_cnt), 0);
      tick();
      chk("empty_done_pulse", int'(bus.done), 0);

      // Dropped steps on 0x0F.
      hs0 = hs_count;
      push_frame(8'h0F);
      bus.spikes = 8'h0F;
      bus.step   = 1'b1;
      tick();
      bus.step = 1'b0;
      tick();
      chk("drop_second_addr", int'(bus.ev_addr), 1);
      bus.spikes = 8'hFF;
      bus.step   = 1'b1;
      tick();
      bus.step = 1'b0;
      chk("drop_ovf1", int'(bus.overflow), 1);
      chk("drop_cnt_hold", int'(bus.spike_cnt), 4);
      tick();
      chk("drop_final_last", int'(bus.ev_last), 1);
      bus.step = 1'b1;
      tick();
      bus.step = 1'b0;
      chk("drop_ovf2", int'(bus.overflow), 1);
      chk("drop_done", int'(bus.done), 1);
      chk("drop_busy", int'(bus.busy), 0);
      tick();
      chk("drop_ovf_clear", int'(bus.overflow), 0);
      chk("drop_no_capture", int'(bus.ev_valid), 0);
      chk("drop_cnt_after", int'(bus.spike_cnt), 4);
      chk("drop_handshakes", hs_count - hs0, 4);

      // Abort 0xFF after three events.
      push_frame(8'hFF);
      bus.spikes = 8'hFF;
      bus.step   = 1'b1;
      tick();
      bus.step = 1'b0;
      tick();
      tick();
      tick();
      chk("abort_fourth_addr", int'(bus.ev_addr), 3);
      rst_n = 1'b0;
      tick();
      exp_q.delete();
      chk("abort_valid", int'(bus.ev_valid), 0);
      chk("abort_done", int'(bus.done), 0);
      chk("abort_cnt", int'(bus.spike_cnt), 0);
      rst_n = 1'b1;
      tick();
      chk("abort_no_done", int'(bus.done), 0);
      chk("abort_idle", int'(bus.ev_valid), 0);

      // Full frame after abort.
      run_frame(8'hFF, 8, 8);

      chk("queue_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
